// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline hazard controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DIV_WAIT = 2'd1, DIV_REL = 2'd2} state_t;
    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stage enables/flushes out
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0] id_rs, id_rt, ex_wreg;
    logic id_uses_rs, id_uses_rt, ex_div, ex_branch_taken, mem_req, mem_ready;
    logic [1:0] ex_memread;
    logic pc_we, if_id_we, if_id_flush, id_exe_we, id_exe_flush;
    logic exe_mem_we, exe_mem_flush, mem_wb_we, div_start, busy;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        input id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wreg,
              ex_div, ex_branch_taken, mem_req, mem_ready,
        output pc_we, if_id_we, if_id_flush, id_exe_we, id_exe_flush,
               exe_mem_we, exe_mem_flush, mem_wb_we, div_start, busy, stall_cycles
    );
    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wreg,
               ex_div, ex_branch_taken, mem_req, mem_ready,
        input pc_we, if_id_we, if_id_flush, id_exe_we, id_exe_flush,
              exe_mem_we, exe_mem_flush, mem_wb_we, div_start, busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use comparator between the ID sources and the EX load target
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [1:0] ex_memread,
    input  logic [4:0] ex_wreg,
    output logic       load_use
);
    assign load_use = ex_memread != LOAD_NONE && ex_wreg != REG_ZERO &&
                      ((id_uses_rs && id_rs == ex_wreg) || (id_uses_rt && id_rt == ex_wreg));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, branch, divide and memory waits
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    pipe_hazard_ctrl_if.master hz
);
    state_t state;
    logic [7:0] div_cnt;
    logic [CNT_W-1:0] stall_cycles;
    logic load_use, mem_stall, div_stall;
    logic pc_we, if_id_we, if_id_flush, id_exe_we, id_exe_flush;
    logic exe_mem_we, exe_mem_flush, mem_wb_we, div_start;

    hazard_detect u_hd (
        .id_rs(hz.id_rs), .id_rt(hz.id_rt),
        .id_uses_rs(hz.id_uses_rs), .id_uses_rt(hz.id_uses_rt),
        .ex_memread(hz.ex_memread), .ex_wreg(hz.ex_wreg),
        .load_use(load_use)
    );

    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign div_stall = (state == RUN && hz.ex_div) || state == DIV_WAIT;

    always_comb begin
        {pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we} = '1;
        {if_id_flush, id_exe_flush, exe_mem_flush, div_start} = '0;
        if (reset) begin
            {pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we} = '0;
            {if_id_flush, id_exe_flush, exe_mem_flush} = '1;
        end else if (mem_stall) begin
            {pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we} = '0;
        end else if (div_stall) begin
            {pc_we, if_id_we, id_exe_we} = '0;
            exe_mem_flush = 1'b1;
            div_start = state == RUN;
        end else if (state == DIV_REL) begin
            pc_we = 1'b1;
        end else if (hz.ex_branch_taken) begin
            {if_id_flush, id_exe_flush} = '1;
        end else if (load_use) begin
            {pc_we, if_id_we} = '0;
            id_exe_flush = 1'b1;
        end
    end

    // divide countdown runs even while memory stalls; only leaving DIV_REL waits on memory
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            div_cnt <= '0;
            stall_cycles <= '0;
        end else begin
            if (!pc_we && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            case (state)
                RUN: if (div_start) begin
                    state <= DIV_WAIT;
                    div_cnt <= 8'(DIV_CYCLES - 1);
                end
                DIV_WAIT: begin
                    div_cnt <= div_cnt - 8'd1;
                    if (div_cnt == 8'd1) state <= DIV_REL;
                end
                DIV_REL: if (!mem_stall) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign hz.pc_we = pc_we;
    assign hz.if_id_we = if_id_we;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_exe_we = id_exe_we;
    assign hz.id_exe_flush = id_exe_flush;
    assign hz.exe_mem_we = exe_mem_we;
    assign hz.exe_mem_flush = exe_mem_flush;
    assign hz.mem_wb_we = mem_wb_we;
    assign hz.div_start = div_start;
    assign hz.busy = ~reset & (state != RUN);
    assign hz.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall/flush sequencing and the stall counter
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hif ();
    pipe_hazard_ctrl #(.DIV_CYCLES(8), .CNT_W(32)) dut (.clk(clk), .reset(reset), .hz(hif));

    always #5 clk = ~clk;

    // {pc_we, if_id_we, if_id_flush, id_exe_we, id_exe_flush, exe_mem_we, exe_mem_flush, mem_wb_we, div_start, busy}
    localparam logic [9:0] P_NORM = 10'b1101010100;
    localparam logic [9:0] P_RST  = 10'b0010101000;
    localparam logic [9:0] P_LU   = 10'b0001110100;
    localparam logic [9:0] P_BR   = 10'b1111110100;
    localparam logic [9:0] P_DSTA = 10'b0000011110;
    localparam logic [9:0] P_DWT  = 10'b0000011101;
    localparam logic [9:0] P_REL  = 10'b1101010101;
    localparam logic [9:0] P_MSB  = 10'b0000000001;
    localparam logic [9:0] P_MS   = 10'b0000000000;

    logic [9:0] o;
    assign o = {hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_exe_we, hif.id_exe_flush,
                hif.exe_mem_we, hif.exe_mem_flush, hif.mem_wb_we, hif.div_start, hif.busy};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
        hif.ex_memread = 2'b00; hif.ex_wreg = 5'd0; hif.ex_div = 1'b0;
        hif.ex_branch_taken = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
    endtask

    task automatic set_lu;
        hif.ex_memread = 2'b01; hif.ex_wreg = 5'd8; hif.id_rs = 5'd8; hif.id_uses_rs = 1'b1;
    endtask

    initial begin
        idle();
        tick(); tick();
        #1 chk("reset_out", 32'(o), 32'(P_RST));
        chk("reset_cnt", hif.stall_cycles, 0);
        reset = 1'b0;
        #1 chk("idle_out", 32'(o), 32'(P_NORM));

        set_lu();
        #1 chk("lu_out", 32'(o), 32'(P_LU));
        tick();
        hif.ex_memread = 2'b00;
        #1 chk("lu_one_bubble", 32'(o), 32'(P_NORM));
        chk("lu_cnt", hif.stall_cycles, 1);

        idle(); hif.ex_memread = 2'b01; hif.id_uses_rs = 1'b1;
        #1 chk("load_r0", 32'(o), 32'(P_NORM));
        idle(); hif.ex_memread = 2'b10; hif.ex_wreg = 5'd8; hif.id_rt = 5'd8; hif.id_rs = 5'd8;
        #1 chk("lu_unused_src", 32'(o), 32'(P_NORM));
        hif.id_uses_rt = 1'b1;
        #1 chk("lu_rt", 32'(o), 32'(P_LU));
        tick();
        idle(); set_lu(); hif.ex_branch_taken = 1'b1;
        #1 chk("branch_over_lu", 32'(o), 32'(P_BR));
        tick();
        idle();
        #1 chk("branch_cnt", hif.stall_cycles, 2);

        hif.ex_div = 1'b1;
        #1 chk("div_start", 32'(o), 32'(P_DSTA));
        tick();
        hif.ex_div = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1 chk($sformatf("div_wait%0d", i), 32'(o), 32'(P_DWT));
            tick();
        end
        hif.ex_div = 1'b1;
        #1 chk("div_rel", 32'(o), 32'(P_REL));
        tick();
        hif.ex_div = 1'b0;
        #1 chk("div_done", 32'(o), 32'(P_NORM));
        chk("div_cnt", hif.stall_cycles, 10);

        hif.ex_div = 1'b1;
        tick();
        hif.ex_div = 1'b0;
        #1 chk("mw_wait0", 32'(o), 32'(P_DWT));
        tick();
        hif.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_stall%0d", i), 32'(o), 32'(P_MSB));
            tick();
        end
        hif.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_resume%0d", i), 32'(o), 32'(P_DWT));
            tick();
        end
        hif.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk($sformatf("mw_rel_hold%0d", i), 32'(o), 32'(P_MSB));
            tick();
        end
        hif.mem_ready = 1'b1;
        #1 chk("mw_rel", 32'(o), 32'(P_REL));
        tick();
        #1 chk("mw_done", 32'(o), 32'(P_NORM));
        chk("mw_cnt", hif.stall_cycles, 20);
        hif.mem_ready = 1'b0;
        #1 chk("mem_stall_run", 32'(o), 32'(P_MS));
        idle();

        hif.ex_div = 1'b1;
        tick();
        hif.ex_div = 1'b0;
        tick(); tick();
        reset = 1'b1; hif.ex_div = 1'b1;
        #1 chk("rst_mid_div", 32'(o), 32'(P_RST));
        tick();
        #1 chk("rst_cnt", hif.stall_cycles, 0);
        chk("rst_hold", 32'(o), 32'(P_RST));
        reset = 1'b0; hif.ex_div = 1'b0;
        #1 chk("rst_run", 32'(o), 32'(P_NORM));
        hif.ex_div = 1'b1;
        #1 chk("rst_restart", 32'(o), 32'(P_DSTA));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
